// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: issues word fetches over a req/ack handshake, buffers them in a
// small prefetch FIFO and drives the registered IF/ID {PC, instruction, valid} outputs.
module if_fetch_unit #(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC,
  output logic [31:0] instruction,
  output logic        valid
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StWait, StDiscard} state_e;

  state_e             r_state;
  state_e             w_state_d;
  logic [31:0]        r_fetch_pc;
  logic [31:0]        w_fetch_pc_d;
  logic [31:0]        r_old_addr;
  logic               r_req;

  logic [31:0]        r_fifo_pc    [DEPTH];
  logic [31:0]        r_fifo_instr [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   w_count_nxt;

  logic [31:0]        r_pc;
  logic [31:0]        r_instr;
  logic               r_valid;

  logic               w_push;
  logic               w_pop;
  logic [31:0]        w_pc_plus4;

  assign w_pc_plus4 = r_fetch_pc + 32'd4;
  assign w_push     = (r_state == StWait) && imem_ack && !branch_taken;
  assign w_pop      = !branch_taken && !freeze && (r_count != '0);

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (w_pop && !w_push) begin
      w_count_nxt = r_count - CNT_W'(1);
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_fetch_pc_d = r_fetch_pc;
    if (branch_taken) begin
      w_fetch_pc_d = {branch_addr[31:2], 2'b00};
    end
    unique case (r_state)
      StIdle: begin
        if ((r_count < DEPTH_C) && !branch_taken) begin
          w_state_d = StWait;
        end
      end
      StWait: begin
        if (branch_taken) begin
          w_state_d = imem_ack ? StIdle : StDiscard;
        end else if (imem_ack) begin
          w_fetch_pc_d = w_pc_plus4;
          w_state_d    = (w_count_nxt < DEPTH_C) ? StWait : StIdle;
        end
      end
      StDiscard: begin
        // The stale request must still complete; its data is thrown away.
        if (imem_ack) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_fetch_pc <= RESET_PC;
      r_old_addr <= RESET_PC;
      r_req      <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_fetch_pc <= w_fetch_pc_d;
      r_req      <= (w_state_d != StIdle);
      if ((r_state == StWait) && branch_taken && !imem_ack) begin
        r_old_addr <= r_fetch_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_pc[r_wr_ptr]    <= w_pc_plus4;
      r_fifo_instr[r_wr_ptr] <= imem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || branch_taken) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + PTR_W'(1);
      end
      r_count <= w_count_nxt;
    end
  end

  // Branch beats freeze; freeze beats a pop.
  always_ff @(posedge clk) begin
    if (rst || branch_taken) begin
      r_pc    <= '0;
      r_instr <= '0;
      r_valid <= 1'b0;
    end else if (freeze) begin
      r_pc    <= r_pc;
      r_instr <= r_instr;
      r_valid <= r_valid;
    end else if (r_count != '0) begin
      r_pc    <= r_fifo_pc[r_rd_ptr];
      r_instr <= r_fifo_instr[r_rd_ptr];
      r_valid <= 1'b1;
    end else begin
      r_pc    <= '0;
      r_instr <= '0;
      r_valid <= 1'b0;
    end
  end

  // While discarding, the bus keeps the abandoned address until its ack arrives.
  assign imem_addr   = (r_state == StDiscard) ? r_old_addr : r_fetch_pc;
  assign imem_req    = r_req;
  assign PC          = r_pc;
  assign instruction = r_instr;
  assign valid       = r_valid;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: one DUT at RESET_PC=0 with a scripted memory, and one at
// RESET_PC=FFFF_FFFC with an always-ack memory returning the address as data.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] PC;
  logic [31:0] instruction;
  logic        valid;

  logic        auto_ack;
  logic        man_ack;
  logic [31:0] man_rdata;

  logic        req1;
  logic [31:0] addr1;
  logic [31:0] pc1;
  logic [31:0] instr1;
  logic        valid1;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  assign imem_ack   = auto_ack ? imem_req : man_ack;
  assign imem_rdata = auto_ack ? imem_addr : man_rdata;

  if_fetch_unit #(.DEPTH(2), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .PC(PC), .instruction(instruction),
    .valid(valid)
  );

  if_fetch_unit #(.DEPTH(2), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .freeze(1'b0), .branch_taken(1'b0), .branch_addr(32'h0),
    .imem_req(req1), .imem_addr(addr1), .imem_ack(req1), .imem_rdata(addr1),
    .PC(pc1), .instruction(instr1), .valid(valid1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0;
    auto_ack = 1'b1; man_ack = 1'b0; man_rdata = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (imem_req !== 1'b0) $display("FAIL rst_req got %0h want 0", imem_req);
    else n_pass++;
    n_checks++; if (imem_addr !== 32'h0) $display("FAIL rst_addr got %h want 0", imem_addr);
    else n_pass++;
    n_checks++; if ({valid, PC, instruction} !== 65'h0)
      $display("FAIL rst_out got v=%0h pc=%h i=%h want zeros", valid, PC, instruction);
    else n_pass++;
    n_checks++; if (addr1 !== 32'hFFFF_FFFC) $display("FAIL rst_addr_wrap got %h want fffffffc", addr1);
    else n_pass++;
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'd4; exp_pc[1] = 32'd8; exp_pc[2] = 32'd12;
    do_reset();
    step();  // issue
    step();  // first ack enters FIFO
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++;
      if (valid !== 1'b1 || PC !== exp_pc[k] || instruction !== exp_pc[k] - 32'd4)
        $display("FAIL stream_%0d got v=%0h pc=%h i=%h want v=1 pc=%h i=%h", k, valid, PC,
                 instruction, exp_pc[k], exp_pc[k] - 32'd4);
      else n_pass++;
    end
  endtask

  task automatic test_freeze();
    logic seen;
    do_reset();
    repeat (5) step();  // outputs now (12,8)
    freeze = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      n_checks++;
      if (valid !== 1'b1 || PC !== 32'd12 || instruction !== 32'd8)
        $display("FAIL freeze_hold_%0d got v=%0h pc=%h i=%h want v=1 pc=c i=8", k, valid, PC,
                 instruction);
      else n_pass++;
    end
    n_checks++; if (imem_req !== 1'b0) $display("FAIL freeze_req got %0h want 0", imem_req);
    else n_pass++;
    freeze = 1'b0;
    step();
    n_checks++; if (valid !== 1'b1 || PC !== 32'd16 || instruction !== 32'd12)
      $display("FAIL freeze_rel0 got v=%0h pc=%h i=%h want pc=10 i=c", valid, PC, instruction);
    else n_pass++;
    step();
    n_checks++; if (valid !== 1'b1 || PC !== 32'd20 || instruction !== 32'd16)
      $display("FAIL freeze_rel1 got v=%0h pc=%h i=%h want pc=14 i=10", valid, PC, instruction);
    else n_pass++;
    seen = 1'b0;
    for (int k = 0; k < 6 && !seen; k++) begin
      step();
      if (valid === 1'b1) seen = 1'b1;
    end
    n_checks++; if (!seen || PC !== 32'd24 || instruction !== 32'd20)
      $display("FAIL freeze_next got seen=%0d pc=%h i=%h want pc=18 i=14", seen, PC, instruction);
    else n_pass++;
  endtask

  task automatic test_branch_discard();
    logic bad;
    do_reset();
    auto_ack = 1'b0;
    step();  // WAIT at 0
    branch_taken = 1'b1; branch_addr = 32'h0000_0103;
    step();
    branch_taken = 1'b0;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0)
      $display("FAIL discard_hold got req=%0h addr=%h want req=1 addr=0", imem_req, imem_addr);
    else n_pass++;
    repeat (3) step();
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0)
      $display("FAIL discard_wait got req=%0h addr=%h want req=1 addr=0", imem_req, imem_addr);
    else n_pass++;
    man_ack = 1'b1; man_rdata = 32'h0000_DEAD;
    step();
    man_ack = 1'b0; auto_ack = 1'b1;
    n_checks++; if (imem_req !== 1'b0 || valid !== 1'b0)
      $display("FAIL discard_done got req=%0h v=%0h want 0 0", imem_req, valid);
    else n_pass++;
    step();
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100)
      $display("FAIL redirect_addr got req=%0h addr=%h want req=1 addr=100", imem_req, imem_addr);
    else n_pass++;
    bad = 1'b0;
    step();
    if (valid === 1'b1 || instruction === 32'h0000_DEAD) bad = 1'b1;
    step();
    n_checks++; if (bad || valid !== 1'b1 || PC !== 32'h104 || instruction !== 32'h100)
      $display("FAIL redirect_first got early=%0d v=%0h pc=%h i=%h want pc=104 i=100", bad,
               valid, PC, instruction);
    else n_pass++;
  endtask

  task automatic test_branch_ack();
    do_reset();
    repeat (3) step();  // outputs (4,0), WAIT on 8 with ack
    branch_taken = 1'b1; branch_addr = 32'h200;
    step();
    branch_taken = 1'b0;
    n_checks++; if ({valid, PC, instruction} !== 65'h0 || imem_req !== 1'b0)
      $display("FAIL bra_ack_flush got v=%0h pc=%h i=%h req=%0h want zeros", valid, PC,
               instruction, imem_req);
    else n_pass++;
    step();
    n_checks++; if (valid !== 1'b0 || imem_addr !== 32'h200)
      $display("FAIL bra_ack_empty got v=%0h addr=%h want v=0 addr=200", valid, imem_addr);
    else n_pass++;
    step();
    step();
    n_checks++; if (valid !== 1'b1 || PC !== 32'h204 || instruction !== 32'h200)
      $display("FAIL bra_ack_first got v=%0h pc=%h i=%h want pc=204 i=200", valid, PC,
               instruction);
    else n_pass++;
  endtask

  task automatic test_branch_freeze();
    do_reset();
    repeat (5) step();  // outputs (12,8), one entry buffered
    freeze = 1'b1; branch_taken = 1'b1; branch_addr = 32'h300;
    step();
    branch_taken = 1'b0; freeze = 1'b0;
    n_checks++; if ({valid, PC, instruction} !== 65'h0)
      $display("FAIL bra_frz_flush got v=%0h pc=%h i=%h want zeros", valid, PC, instruction);
    else n_pass++;
    step();
    n_checks++; if (valid !== 1'b0 || imem_addr !== 32'h300)
      $display("FAIL bra_frz_empty got v=%0h addr=%h want v=0 addr=300", valid, imem_addr);
    else n_pass++;
    step();
    step();
    n_checks++; if (valid !== 1'b1 || PC !== 32'h304 || instruction !== 32'h300)
      $display("FAIL bra_frz_first got v=%0h pc=%h i=%h want pc=304 i=300", valid, PC,
               instruction);
    else n_pass++;
  endtask

  task automatic test_wrap();
    do_reset();
    step();
    step();
    n_checks++; if (addr1 !== 32'h0) $display("FAIL wrap_addr got %h want 0", addr1);
    else n_pass++;
    step();
    n_checks++; if (valid1 !== 1'b1 || pc1 !== 32'h0 || instr1 !== 32'hFFFF_FFFC)
      $display("FAIL wrap_pc got v=%0h pc=%h i=%h want v=1 pc=0 i=fffffffc", valid1, pc1, instr1);
    else n_pass++;
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    step();
    step();  // WAIT, one entry buffered
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++; if (imem_req !== 1'b0 || valid !== 1'b0 || imem_addr !== 32'h0)
      $display("FAIL rst_wait got req=%0h v=%0h addr=%h want 0 0 0", imem_req, valid, imem_addr);
    else n_pass++;
    step();
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0)
      $display("FAIL rst_restart got req=%0h addr=%h want req=1 addr=0", imem_req, imem_addr);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_freeze();
    test_branch_discard();
    test_branch_ack();
    test_branch_freeze();
    test_wrap();
    test_reset_in_wait();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
